status_reg_arbiter: RTL and testbench
=====================================

Name: status_reg_arbiter

Overview:
- Shares one status_register_file instance between NUM_REQ requesters (fetch control, debug/config port, ...) using round-robin arbitration.
- Registers the granted request into the file's input port and steers the file's responses back to the owner via the file's tag path.
- Sits directly in front of the status register file in the instruction-cache control path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REQ_ID_WIDTH, 1, width of requester id; must equal ceil(log2(NUM_REQ)), min 1; drives file TAG_WIDTH.
- WORD_WIDTH, 12, data word width; matches file.
- ADDR_WIDTH, 3, register address width; matches file.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- i_halt  in  1  global stall; also drives file halt
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_wen  in  NUM_REQ  1=write, 0=read
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_data  in  NUM_REQ*WORD_WIDTH  flattened write data
- o_req_ready  out  NUM_REQ  one-hot grant/accept
- o_srf_tag  out  REQ_ID_WIDTH  to file i_tag
- o_srf_addr  out  ADDR_WIDTH  to file i_addr
- o_srf_data  out  WORD_WIDTH  to file i_data
- o_srf_wen  out  1  to file i_wen
- o_srf_valid  out  1  to file i_valid
- o_srf_halt  out  1  to file i_halt
- i_srf_tag  in  REQ_ID_WIDTH  from file o_tag
- i_srf_data  in  WORD_WIDTH  from file o_data
- i_srf_valid  in  1  from file o_valid
- o_rsp_valid  out  NUM_REQ  one-hot read-data pulse
- o_rsp_data  out  WORD_WIDTH  shared read data
- o_wr_ack  out  NUM_REQ  one-hot write-complete pulse

Behaviour:
- Reset (arst_n=0 at a clk edge): all o_srf_* = 0, rr pointer = 0, read/write in-flight flags = 0, o_rsp_valid = 0, o_wr_ack = 0. o_req_ready = 0 while arst_n=0. Reset mid-transaction drops in-flight ops; no response is emitted for them.
- o_srf_halt = i_halt (combinational passthrough).
- Accept: when i_halt=0, grant the first valid requester scanning from rr pointer upward with wrap (k = ptr, ptr+1, ..., NUM_REQ-1, 0, ...). o_req_ready is combinational, one-hot, and 0 if no request is valid. Transfer occurs when ready & valid in the same cycle.
- Issue register: on transfer, next cycle o_srf_valid=1, tag=granted id, and addr/data/wen come from the winner. If i_halt=0 and there is no transfer, o_srf_valid=0 next cycle.
- rr pointer: after a transfer, ptr <= (granted+1) mod NUM_REQ. Unchanged without a transfer.
- i_halt=1: o_req_ready=0. Issue register, pointer and in-flight flags hold. No o_rsp_valid or o_wr_ack pulses.
- In-flight tracking: the file's o_valid is sticky (it holds across idle cycles), so i_srf_valid alone is not used as a response strobe.
  - rd_inflight <= o_srf_valid & ~o_srf_wen when i_halt=0.
  - wr_inflight <= o_srf_valid & o_srf_wen when i_halt=0.
- Response (combinational):
  - o_rsp_valid[k] = rd_inflight & i_srf_valid & (i_srf_tag==k) & ~i_halt.
  - o_wr_ack[k] = wr_inflight & (i_srf_tag==k) & ~i_halt.
  - o_rsp_data = i_srf_data.
- Latency: read accept cycle T -> file input T+1 -> o_rsp_valid at T+2, plus any halt cycles. Write ack also at T+2.
- Back-to-back: one op can be accepted per non-halted cycle. Responses return in issue order.
- Write-then-read to the same address from any requesters in consecutive accepts: the read returns the new data.
- Simultaneous requests: only one is granted per cycle. Losers keep valid asserted and hold their request fields stable until ready.

Optional Feature:
- Macro STATUS_ARB_STATS_EN.
- Defined: adds output o_conflict_cnt, 16 bits, reset 0. Increments on every non-halted cycle with >=2 requests valid. Saturates at 16'hFFFF and does not wrap.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single read: reset, req0 writes addr 3 data 12'hABC at T; req0 reads addr 3 at T+1 -> o_wr_ack[0] at T+2, o_rsp_valid[0]=1 with data 12'hABC at T+3, rsp_valid[1]=0.
- Round-robin: both requesters hold continuous reads (addr 1, addr 2) for 6 cycles -> grants alternate 0,1,0,1,0,1; responses carry tag-matched data in issue order.
- Halt: read accepted at T, i_halt=1 on T+1..T+3 -> o_req_ready=0 and no pulses during halt; o_rsp_valid exactly once at T+5 with correct data.
- Sticky o_valid: one read, then 5 idle cycles -> exactly one o_rsp_valid pulse, though file o_valid stays 1.
- Reset mid-op: read accepted at T, arst_n=0 at T+1 -> no response ever; after release all outputs 0 and ptr=0 (next contended grant goes to req0).
- STATUS_ARB_STATS_EN: 4 contended cycles with 1 halted among them -> o_conflict_cnt=3; preload near max -> holds 16'hFFFF.

Source files
------------

// File: rtl/status_reg_arbiter_if.sv
// status_reg_arbiter_if: requester, status-register-file and response bundle for status_reg_arbiter.
// Ports: master modport drives requests, halt and file responses; slave modport (the arbiter)
// drives grants, the registered file request and the per-requester responses.
interface status_reg_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int REQ_ID_WIDTH = 1,
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
);
  logic i_halt;
  logic [NUM_REQ-1:0] i_req_valid;
  logic [NUM_REQ-1:0] i_req_wen;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*WORD_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0] o_req_ready;
  logic [REQ_ID_WIDTH-1:0] o_srf_tag;
  logic [ADDR_WIDTH-1:0] o_srf_addr;
  logic [WORD_WIDTH-1:0] o_srf_data;
  logic o_srf_wen;
  logic o_srf_valid;
  logic o_srf_halt;
  logic [REQ_ID_WIDTH-1:0] i_srf_tag;
  logic [WORD_WIDTH-1:0] i_srf_data;
  logic i_srf_valid;
  logic [NUM_REQ-1:0] o_rsp_valid;
  logic [WORD_WIDTH-1:0] o_rsp_data;
  logic [NUM_REQ-1:0] o_wr_ack;
  modport master (
    output i_halt, i_req_valid, i_req_wen, i_req_addr, i_req_data, i_srf_tag, i_srf_data, i_srf_valid,
    input o_req_ready, o_srf_tag, o_srf_addr, o_srf_data, o_srf_wen, o_srf_valid, o_srf_halt,
    input o_rsp_valid, o_rsp_data, o_wr_ack
  );
  modport slave (
    input i_halt, i_req_valid, i_req_wen, i_req_addr, i_req_data, i_srf_tag, i_srf_data, i_srf_valid,
    output o_req_ready, o_srf_tag, o_srf_addr, o_srf_data, o_srf_wen, o_srf_valid, o_srf_halt,
    output o_rsp_valid, o_rsp_data, o_wr_ack
  );
endinterface

// File: rtl/status_reg_arbiter.sv
// status_reg_arbiter: round-robin sharing of one status register file between NUM_REQ requesters.
// Ports: clk, arst_n (synchronous, active-low), bus (status_reg_arbiter_if.slave: requests/grants,
// registered file request, file response, per-requester read data and write acks).
// Optional: define STATUS_ARB_STATS_EN to add o_conflict_cnt, a saturating count of contended cycles.
module status_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REQ_ID_WIDTH = 1,
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input logic clk,
  input logic arst_n,
  status_reg_arbiter_if.slave bus
`ifdef STATUS_ARB_STATS_EN
  ,
  output logic [15:0] o_conflict_cnt
`endif
);
  logic [REQ_ID_WIDTH-1:0] ptr;
  logic [REQ_ID_WIDTH-1:0] gid;
  logic [NUM_REQ-1:0] gnt;
  logic xfer;
  logic rd_inflight;
  logic wr_inflight;
  // Scan downward from the farthest offset so the nearest valid requester after ptr wins last.
  always_comb begin
    gnt = '0;
    gid = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (bus.i_req_valid[(int'(ptr) + j) % NUM_REQ]) begin
        gnt = NUM_REQ'(1) << ((int'(ptr) + j) % NUM_REQ);
        gid = REQ_ID_WIDTH'((int'(ptr) + j) % NUM_REQ);
      end
  end
  assign bus.o_req_ready = (arst_n && !bus.i_halt) ? gnt : '0;
  assign xfer = |bus.o_req_ready;
  assign bus.o_srf_halt = bus.i_halt;
  assign bus.o_rsp_data = bus.i_srf_data;
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      bus.o_srf_valid <= 1'b0;
      bus.o_srf_tag <= '0;
      bus.o_srf_addr <= '0;
      bus.o_srf_data <= '0;
      bus.o_srf_wen <= 1'b0;
      ptr <= '0;
      rd_inflight <= 1'b0;
      wr_inflight <= 1'b0;
    end else if (!bus.i_halt) begin
      bus.o_srf_valid <= xfer;
      // The file's o_valid is sticky, so these flags mark the one cycle its output is fresh.
      rd_inflight <= bus.o_srf_valid & ~bus.o_srf_wen;
      wr_inflight <= bus.o_srf_valid & bus.o_srf_wen;
      if (xfer) begin
        bus.o_srf_tag <= gid;
        bus.o_srf_addr <= bus.i_req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
        bus.o_srf_data <= bus.i_req_data[gid*WORD_WIDTH +: WORD_WIDTH];
        bus.o_srf_wen <= bus.i_req_wen[gid];
        ptr <= (gid == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
      end
    end
  end
  always_comb begin
    bus.o_rsp_valid = '0;
    bus.o_wr_ack = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.o_rsp_valid[k] = rd_inflight & bus.i_srf_valid & (bus.i_srf_tag == REQ_ID_WIDTH'(k)) & ~bus.i_halt;
      bus.o_wr_ack[k] = wr_inflight & (bus.i_srf_tag == REQ_ID_WIDTH'(k)) & ~bus.i_halt;
    end
  end
`ifdef STATUS_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!arst_n)
      o_conflict_cnt <= '0;
    else if (!bus.i_halt && $countones(bus.i_req_valid) >= 2 && o_conflict_cnt != 16'hFFFF)
      o_conflict_cnt <= o_conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_status_reg_arbiter.sv
// tb_status_reg_arbiter: randomized and directed checks of status_reg_arbiter against a queue-based model.
module tb_status_reg_arbiter;
  localparam int N = 2;
  localparam int IW = 1;
  localparam int W = 12;
  localparam int A = 3;
  localparam int VW = 3 * N + 2 + IW + A + 1 + W + W;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  status_reg_arbiter_if #(.NUM_REQ(N), .REQ_ID_WIDTH(IW), .WORD_WIDTH(W), .ADDR_WIDTH(A)) bus ();
`ifdef STATUS_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif
  status_reg_arbiter #(.NUM_REQ(N), .REQ_ID_WIDTH(IW), .WORD_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
`ifdef STATUS_ARB_STATS_EN
    ,
    .o_conflict_cnt(conflict_cnt)
`endif
  );
  // Status register file stand-in: one-cycle registered access, sticky o_valid, honours halt.
  logic [W-1:0] fmem [8] = '{default: '0};
  logic [W-1:0] f_data = '0;
  logic [IW-1:0] f_tag = '0;
  logic f_valid = 1'b0;
  always @(posedge clk)
    if (!bus.o_srf_halt && bus.o_srf_valid) begin
      if (bus.o_srf_wen) fmem[bus.o_srf_addr] <= bus.o_srf_data;
      else f_data <= fmem[bus.o_srf_addr];
      f_tag <= bus.o_srf_tag;
      f_valid <= 1'b1;
    end
  assign bus.i_srf_tag = f_tag;
  assign bus.i_srf_data = f_data;
  assign bus.i_srf_valid = f_valid;
  // Reference model: round-robin pointer, in-order op queue aged by non-halted cycles, shadow memory.
  typedef struct {int left; bit wr; int id; logic [W-1:0] d;} op_t;
  op_t q[$];
  logic [W-1:0] smem [8] = '{default: '0};
  int ptr_m = 0;
  int gnt_m;
  logic es_valid = 1'b0;
  logic [IW-1:0] es_tag = '0;
  logic [A-1:0] es_addr = '0;
  logic es_wen = 1'b0;
  logic [W-1:0] es_data = '0;
  logic [N-1:0] obs_ready, obs_rsp, obs_ack;
  logic [W-1:0] obs_data;
  logic [VW-1:0] exp_v, obs_v;
  int checks = 0;
  int errors = 0;
  task automatic set_req(input int k, input bit v, input bit w, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.i_req_valid[k] = v;
    bus.i_req_wen[k] = w;
    bus.i_req_addr[k*A +: A] = a;
    bus.i_req_data[k*W +: W] = d;
  endtask
  task automatic tick();
    int g;
    bit rst_c, h;
    logic [N-1:0] er, ersp, eack, orsp, oack;
    logic [W-1:0] ed, od;
    logic [IW+A+1+W-1:0] es, os;
    logic [A-1:0] a;
    @(negedge clk);
    rst_c = !arst_n;
    h = bus.i_halt;
    g = -1;
    if (!rst_c && !h)
      for (int j = 0; j < N; j++) begin
        int k = (ptr_m + j) % N;
        if (g < 0 && bus.i_req_valid[k]) g = k;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ersp = '0;
    eack = '0;
    ed = '0;
    if (!rst_c && !h) begin
      foreach (q[i]) q[i].left = q[i].left - 1;
      if (q.size() > 0 && q[0].left == 0) begin
        if (q[0].wr) eack[q[0].id] = 1'b1;
        else begin
          ersp[q[0].id] = 1'b1;
          ed = q[0].d;
        end
        void'(q.pop_front());
      end
    end
    obs_ready = bus.o_req_ready;
    obs_rsp = bus.o_rsp_valid;
    obs_ack = bus.o_wr_ack;
    obs_data = bus.o_rsp_data;
    orsp = rst_c ? '0 : bus.o_rsp_valid;
    oack = rst_c ? '0 : bus.o_wr_ack;
    es = es_valid ? {es_tag, es_addr, es_wen, es_data} : '0;
    os = es_valid ? {bus.o_srf_tag, bus.o_srf_addr, bus.o_srf_wen, bus.o_srf_data} : '0;
    od = (|ersp) ? bus.o_rsp_data : '0;
    exp_v = {er, ersp, eack, es_valid, h, es, ed};
    obs_v = {bus.o_req_ready, orsp, oack, bus.o_srf_valid, bus.o_srf_halt, os, od};
    gnt_m = g;
    if (rst_c) begin
      ptr_m = 0;
      q.delete();
      es_valid = 1'b0;
      es_tag = '0;
      es_addr = '0;
      es_wen = 1'b0;
      es_data = '0;
    end else if (!h) begin
      es_valid = (g >= 0);
      if (g >= 0) begin
        a = bus.i_req_addr[g*A +: A];
        es_tag = IW'(g);
        es_addr = a;
        es_wen = bus.i_req_wen[g];
        es_data = bus.i_req_data[g*W +: W];
        ptr_m = (g + 1) % N;
        if (es_wen) smem[a] = es_data;
        q.push_back('{2, es_wen, g, es_wen ? '0 : smem[a]});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.i_halt = 1'b0;
    set_req(0, 1, 0, 3'd1, '0);
    set_req(1, 1, 1, 3'd2, 12'h123);
    arst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (obs_ready !== 2'b00) begin errors++; $display("FAIL reset_ready cyc=%0d obs=%b exp=00", c, obs_ready); end
      checks++;
    end
    arst_n = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    #1;
    if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_wr_ack, bus.o_srf_valid, bus.o_srf_tag, bus.o_srf_addr,
         bus.o_srf_wen, bus.o_srf_data, bus.o_srf_halt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs obs=%b%b%b%b%h%h%b%h%b exp=all zero", bus.o_req_ready, bus.o_rsp_valid,
               bus.o_wr_ack, bus.o_srf_valid, bus.o_srf_tag, bus.o_srf_addr, bus.o_srf_wen, bus.o_srf_data, bus.o_srf_halt);
    end
    checks++;
  endtask
  task automatic test_single();
    for (int c = 0; c < 5; c++) begin
      set_req(0, c < 2, c == 0, 3'd3, (c == 0) ? 12'hABC : 12'h000);
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL single cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      if (c == 2) begin
        if (obs_ack !== 2'b01 || obs_rsp !== 2'b00) begin errors++; $display("FAIL single_wr_ack obs=%b/%b exp=01/00", obs_ack, obs_rsp); end
        checks++;
      end
      if (c == 3) begin
        if (obs_rsp !== 2'b01 || obs_data !== 12'hABC) begin errors++; $display("FAIL single_rd obs=%b/%h exp=01/abc", obs_rsp, obs_data); end
        checks++;
      end
    end
  endtask
  task automatic test_round_robin();
    int pulses = 0;
    set_req(0, 1, 1, 3'd1, 12'h5A1);
    set_req(1, 1, 1, 3'd2, 12'h3C7);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL rr_pre cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      if (gnt_m >= 0) set_req(gnt_m, 0, 0, '0, '0);
    end
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    set_req(0, 1, 0, 3'd1, '0);
    set_req(1, 1, 0, 3'd2, '0);
    for (int c = 0; c < 9; c++) begin
      if (c == 6) begin
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
      end
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL rr cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      if (c < 6) begin
        if (obs_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_grant cyc=%0d obs=%b", c, obs_ready); end
        checks++;
      end
      if (obs_rsp[0] && obs_data !== 12'h5A1) begin errors++; $display("FAIL rr_data0 cyc=%0d obs=%h exp=5a1", c, obs_data); end
      if (obs_rsp[1] && obs_data !== 12'h3C7) begin errors++; $display("FAIL rr_data1 cyc=%0d obs=%h exp=3c7", c, obs_data); end
      pulses += $countones(obs_rsp);
    end
    if (pulses != 6) begin errors++; $display("FAIL rr_pulses obs=%0d exp=6", pulses); end
    checks++;
  endtask
  task automatic test_halt();
    int pulses = 0;
    for (int c = 0; c < 9; c++) begin
      bus.i_halt = (c >= 1 && c <= 3);
      set_req(0, c == 0, 0, 3'd3, '0);
      if (c == 1) set_req(1, 1, 0, 3'd1, '0);
      tick();
      if (gnt_m == 1) set_req(1, 0, 0, '0, '0);
      if (obs_v !== exp_v) begin errors++; $display("FAIL halt cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      if (c >= 1 && c <= 3) begin
        if ({obs_ready, obs_rsp, obs_ack} !== '0) begin errors++; $display("FAIL halt_quiet cyc=%0d obs=%b%b%b exp=0", c, obs_ready, obs_rsp, obs_ack); end
        checks++;
      end
      if (c == 5) begin
        if (obs_rsp !== 2'b01 || obs_data !== 12'hABC) begin errors++; $display("FAIL halt_rsp obs=%b/%h exp=01/abc", obs_rsp, obs_data); end
        checks++;
      end
      pulses += int'(obs_rsp[0]);
    end
    bus.i_halt = 1'b0;
    if (pulses != 1) begin errors++; $display("FAIL halt_pulses obs=%0d exp=1", pulses); end
    checks++;
  endtask
  task automatic test_sticky();
    int pulses = 0;
    for (int c = 0; c < 7; c++) begin
      set_req(1, c == 0, 0, 3'd2, '0);
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL sticky cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      pulses += $countones(obs_rsp);
    end
    if (pulses != 1 || f_valid !== 1'b1) begin errors++; $display("FAIL sticky_pulses obs=%0d exp=1", pulses); end
    checks++;
  endtask
  task automatic test_reset_mid();
    int pulses = 0;
    set_req(0, 1, 0, 3'd3, '0);
    tick();
    set_req(0, 0, 0, '0, '0);
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    #1;
    if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_wr_ack, bus.o_srf_valid, bus.o_srf_tag, bus.o_srf_addr,
         bus.o_srf_wen, bus.o_srf_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs obs=%b%b%b%b exp=0", bus.o_req_ready, bus.o_rsp_valid, bus.o_wr_ack, bus.o_srf_valid);
    end
    checks++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL midreset cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      pulses += $countones(obs_rsp) + $countones(obs_ack);
    end
    if (pulses != 0) begin errors++; $display("FAIL midreset_pulses obs=%0d exp=0", pulses); end
    checks++;
    set_req(0, 1, 0, 3'd1, '0);
    set_req(1, 1, 0, 3'd2, '0);
    tick();
    if (obs_ready !== 2'b01) begin errors++; $display("FAIL midreset_ptr obs=%b exp=01", obs_ready); end
    checks++;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL midreset_drain cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 404; c++) begin
      bus.i_halt = (c < 400) && ($urandom_range(0, 7) == 0);
      for (int k = 0; k < N; k++)
        if (c < 400 && !bus.i_req_valid[k] && $urandom_range(0, 1) == 1)
          set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A'($urandom_range(0, 7)), W'($urandom));
        else if (c >= 400) set_req(k, 0, 0, '0, '0);
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
      if (gnt_m >= 0) set_req(gnt_m, 0, 0, '0, '0);
    end
    bus.i_halt = 1'b0;
  endtask
`ifdef STATUS_ARB_STATS_EN
  task automatic test_stats();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    set_req(0, 1, 0, 3'd1, '0);
    set_req(1, 1, 0, 3'd2, '0);
    for (int c = 0; c < 4; c++) begin
      bus.i_halt = (c == 1);
      tick();
    end
    bus.i_halt = 1'b0;
    if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL stats_count obs=%0d exp=3", conflict_cnt); end
    checks++;
    for (int c = 0; c < 65540; c++) begin
      tick();
      if (obs_v !== exp_v) begin errors++; $display("FAIL stats_run cyc=%0d obs=%h exp=%h", c, obs_v, exp_v); end
      checks++;
    end
    if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat obs=%h exp=ffff", conflict_cnt); end
    checks++;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    for (int c = 0; c < 3; c++) tick();
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_halt();
    test_sticky();
    test_reset_mid();
    test_random();
`ifdef STATUS_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
